// File: rtl/msi_snoop_ctrl.sv
// msi_snoop_ctrl: snooping MSI coherence controller serving NPROC direct-mapped caches over one shared bus
// Ports:
//   i_clock, i_reset            sole clock; synchronous active-high reset
//   i_req_*, o_req_ready        request handshake (proc, index, tag, op 0=write/1=read, write data)
//   o_resp_*                    one-cycle completion pulse with hit, illegal-proc error and line data
//   o_mem_*, i_mem_rdata        backing memory port, read data valid the cycle after a read enable
//   o_bus_valid, o_bus_msg      snoop broadcast: 00 write miss, 01 read miss, 10 invalidate, 11 none
//   i_dbg_*, o_dbg_*            combinational view of one cache line (state I=00 S=01 M=10 E=11)
// Macro MSI_SNOOP_MESI_EN: when defined, read misses filled from memory install the line Exclusive.
module msi_snoop_ctrl #(
  parameter int NPROC = 3,
  parameter int NLINES = 4,
  parameter int TAG_W = 3,
  parameter int DATA_W = 16,
  localparam int PID_W = $clog2(NPROC),
  localparam int IDX_W = $clog2(NLINES)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [PID_W-1:0]       i_req_proc,
  input  logic [IDX_W-1:0]       i_req_index,
  input  logic [TAG_W-1:0]       i_req_tag,
  input  logic                   i_req_op,
  input  logic [DATA_W-1:0]      i_req_wdata,
  output logic                   o_resp_valid,
  output logic                   o_resp_hit,
  output logic                   o_resp_err,
  output logic [DATA_W-1:0]      o_resp_rdata,
  output logic                   o_mem_en,
  output logic                   o_mem_we,
  output logic [TAG_W+IDX_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic [DATA_W-1:0]      i_mem_rdata,
  output logic                   o_bus_valid,
  output logic [1:0]             o_bus_msg,
  input  logic [PID_W-1:0]       i_dbg_proc,
  input  logic [IDX_W-1:0]       i_dbg_index,
  output logic [1:0]             o_dbg_state,
  output logic [TAG_W-1:0]       o_dbg_tag,
  output logic [DATA_W-1:0]      o_dbg_data
);
`ifdef MSI_SNOOP_MESI_EN
  localparam bit MESI = 1'b1;
`else
  localparam bit MESI = 1'b0;
`endif
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10, ST_E = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_SNOOP, S_MEMWAIT, S_UPDATE, S_RESP} state_t;
  state_t r_state, w_next;
  logic [1:0]        r_line_st   [NPROC][NLINES];
  logic [TAG_W-1:0]  r_line_tag  [NPROC][NLINES];
  logic [DATA_W-1:0] r_line_data [NPROC][NLINES];
  logic [PID_W-1:0]  r_req_proc;
  logic [IDX_W-1:0]  r_req_idx;
  logic [TAG_W-1:0]  r_req_tag;
  logic              r_req_op;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_hit, r_err, r_from_mem;
  logic              w_err, w_hit, w_sup_ok, w_sup_m, w_dbg_ok, w_resp;
  logic [PID_W-1:0]  w_rp, w_sup;
  logic [1:0]        w_vst, w_new_st, w_bus_msg;
  logic [TAG_W-1:0]  w_vtag;
  logic [DATA_W-1:0] w_vdata;
  // An illegal requester is redirected to cache 0 so array reads stay in range; its results are discarded.
  assign w_err = {1'b0, r_req_proc} >= (PID_W+1)'(NPROC);
  assign w_rp = w_err ? '0 : r_req_proc;
  assign w_vst = r_line_st[w_rp][r_req_idx];
  assign w_vtag = r_line_tag[w_rp][r_req_idx];
  assign w_vdata = r_line_data[w_rp][r_req_idx];
  assign w_hit = ~w_err & (w_vtag == r_req_tag) & (w_vst != ST_I);
  // Descending scan so the lowest-numbered matching peer wins.
  always_comb begin
    w_sup_ok = 1'b0;
    w_sup = '0;
    for (int p = NPROC - 1; p >= 0; p--)
      if (PID_W'(p) != w_rp && r_line_st[p][r_req_idx] != ST_I && r_line_tag[p][r_req_idx] == r_req_tag) begin
        w_sup_ok = 1'b1;
        w_sup = PID_W'(p);
      end
  end
  assign w_sup_m = r_line_st[w_sup][r_req_idx] == ST_M;
  assign w_new_st = r_req_op ? (r_hit ? w_vst : ((MESI && r_from_mem) ? ST_E : ST_S)) : ST_M;
  assign w_bus_msg = r_req_op ? (r_hit ? 2'b11 : 2'b01) : (!r_hit ? 2'b00 : (w_vst == ST_S ? 2'b10 : 2'b11));
  always_comb begin
    w_next = r_state;
    o_mem_en = 1'b0;
    o_mem_we = 1'b0;
    o_mem_addr = '0;
    o_mem_wdata = '0;
    o_bus_valid = 1'b0;
    o_bus_msg = 2'b00;
    case (r_state)
      S_IDLE: w_next = i_req_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP: w_next = w_err ? S_RESP : w_hit ? S_UPDATE : (w_vst == ST_M) ? S_WB : S_SNOOP;
      S_WB: begin
        w_next = S_SNOOP;
        o_mem_en = 1'b1;
        o_mem_we = 1'b1;
        o_mem_addr = {w_vtag, r_req_idx};
        o_mem_wdata = w_vdata;
      end
      S_SNOOP: begin
        w_next = w_sup_ok ? S_UPDATE : S_MEMWAIT;
        // A clean supplier needs no memory traffic; a dirty one is written back as it supplies.
        if (!w_sup_ok || w_sup_m) begin
          o_mem_en = 1'b1;
          o_mem_we = w_sup_ok;
          o_mem_addr = {r_req_tag, r_req_idx};
          o_mem_wdata = w_sup_ok ? r_line_data[w_sup][r_req_idx] : '0;
        end
      end
      S_MEMWAIT: w_next = S_UPDATE;
      S_UPDATE: begin
        w_next = S_RESP;
        o_bus_valid = 1'b1;
        o_bus_msg = w_bus_msg;
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_reset) begin
      o_mem_en = 1'b0;
      o_mem_we = 1'b0;
      o_mem_addr = '0;
      o_mem_wdata = '0;
      o_bus_valid = 1'b0;
      o_bus_msg = 2'b00;
    end
  end
  assign o_req_ready = ~i_reset & (r_state == S_IDLE);
  assign w_resp = ~i_reset & (r_state == S_RESP);
  assign o_resp_valid = w_resp;
  assign o_resp_hit = w_resp & r_hit;
  assign o_resp_err = w_resp & r_err;
  assign o_resp_rdata = (w_resp & ~r_err) ? r_line_data[w_rp][r_req_idx] : '0;
  assign w_dbg_ok = {1'b0, i_dbg_proc} < (PID_W+1)'(NPROC);
  assign o_dbg_state = w_dbg_ok ? r_line_st[i_dbg_proc][i_dbg_index] : 2'b00;
  assign o_dbg_tag = w_dbg_ok ? r_line_tag[i_dbg_proc][i_dbg_index] : '0;
  assign o_dbg_data = w_dbg_ok ? r_line_data[i_dbg_proc][i_dbg_index] : '0;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_req_proc <= '0;
      r_req_idx <= '0;
      r_req_tag <= '0;
      r_req_op <= 1'b0;
      r_req_wdata <= '0;
      r_hit <= 1'b0;
      r_err <= 1'b0;
      r_from_mem <= 1'b0;
      for (int p = 0; p < NPROC; p++)
        for (int l = 0; l < NLINES; l++) begin
          r_line_st[p][l] <= ST_I;
          r_line_tag[p][l] <= '0;
          r_line_data[p][l] <= '0;
        end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_req_proc <= i_req_proc;
          r_req_idx <= i_req_index;
          r_req_tag <= i_req_tag;
          r_req_op <= i_req_op;
          r_req_wdata <= i_req_wdata;
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          r_err <= w_err;
        end
        S_SNOOP: begin
          r_from_mem <= ~w_sup_ok;
          if (w_sup_ok) r_line_data[w_rp][r_req_idx] <= r_line_data[w_sup][r_req_idx];
        end
        S_MEMWAIT: r_line_data[w_rp][r_req_idx] <= i_mem_rdata;
        S_UPDATE: begin
          // Writes kill every other copy; read misses demote other copies to Shared.
          for (int p = 0; p < NPROC; p++)
            if (PID_W'(p) != w_rp && r_line_st[p][r_req_idx] != ST_I && r_line_tag[p][r_req_idx] == r_req_tag) begin
              if (!r_req_op) r_line_st[p][r_req_idx] <= ST_I;
              else if (!r_hit) r_line_st[p][r_req_idx] <= ST_S;
            end
          r_line_st[w_rp][r_req_idx] <= w_new_st;
          r_line_tag[w_rp][r_req_idx] <= r_req_tag;
          if (!r_req_op) r_line_data[w_rp][r_req_idx] <= r_req_wdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// tb_msi_snoop_ctrl: randomized check of msi_snoop_ctrl against a transaction-level coherence model
module tb_msi_snoop_ctrl;
  localparam int NP = 3, NL = 4;
`ifdef MSI_SNOOP_MESI_EN
  localparam bit MESI = 1'b1;
`else
  localparam bit MESI = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [1:0] req_proc = '0, req_index = '0, dbg_proc = '0, dbg_index = '0;
  logic [2:0] req_tag = '0;
  logic [15:0] req_wdata = '0, resp_rdata, mem_wdata, mem_rdata = '0, dbg_data;
  logic resp_valid, resp_hit, resp_err, mem_en, mem_we, bus_valid;
  logic [4:0] mem_addr;
  logic [1:0] bus_msg, dbg_state;
  logic [2:0] dbg_tag;
  always #5 clk = ~clk;
  msi_snoop_ctrl dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_proc(req_proc), .i_req_index(req_index), .i_req_tag(req_tag), .i_req_op(req_op),
    .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .o_resp_hit(resp_hit), .o_resp_err(resp_err),
    .o_resp_rdata(resp_rdata), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_bus_valid(bus_valid), .o_bus_msg(bus_msg),
    .i_dbg_proc(dbg_proc), .i_dbg_index(dbg_index), .o_dbg_state(dbg_state), .o_dbg_tag(dbg_tag),
    .o_dbg_data(dbg_data)
  );
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [15:0] mem [32];
  int ref_mem [32];
  bit pend = 1'b0;
  logic [4:0] paddr = '0;
  int obs_mem [$];
  int obs_bus [$];
  // Memory device: read data appears only in the cycle after the read enable, garbage otherwise.
  always @(negedge clk) begin
    mem_rdata = pend ? mem[paddr] : 16'($urandom);
    pend = 1'b0;
    if (mem_en) begin
      obs_mem.push_back((int'(mem_we) << 24) | (int'(mem_addr) << 16) | (mem_we ? int'(mem_wdata) : 0));
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin
        pend = 1'b1;
        paddr = mem_addr;
      end
    end
    if (bus_valid) obs_bus.push_back(int'(bus_msg));
  end
  int m_st [NP][NL], m_tag [NP][NL], m_data [NP][NL];
  int e_lat, e_hit, e_err, e_rd, e_bus;
  int e_mem [$];
  task automatic model_clear();
    for (int p = 0; p < NP; p++)
      for (int l = 0; l < NL; l++) begin
        m_st[p][l] = 0;
        m_tag[p][l] = 0;
        m_data[p][l] = 0;
      end
  endtask
  // States: 0=I 1=S 2=M 3=E. Expected memory ops packed as we<<24 | addr<<16 | data.
  task automatic model(input int p, input int i, input int t, input int op, input int wd);
    int sup, a, from_mem;
    e_mem.delete();
    e_err = p >= NP;
    e_hit = 0;
    e_bus = -1;
    e_rd = 0;
    e_lat = 2;
    if (e_err) return;
    e_hit = m_st[p][i] != 0 && m_tag[p][i] == t;
    a = (t << 2) | i;
    from_mem = 0;
    if (e_hit) begin
      e_lat = 3;
      e_bus = (op == 1) ? 3 : (m_st[p][i] == 1 ? 2 : 3);
    end else begin
      e_lat = 4;
      if (m_st[p][i] == 2) begin
        e_mem.push_back((1 << 24) | (((m_tag[p][i] << 2) | i) << 16) | m_data[p][i]);
        ref_mem[(m_tag[p][i] << 2) | i] = m_data[p][i];
        e_lat++;
      end
      sup = -1;
      for (int q = NP - 1; q >= 0; q--)
        if (q != p && m_st[q][i] != 0 && m_tag[q][i] == t) sup = q;
      if (sup >= 0) begin
        m_data[p][i] = m_data[sup][i];
        if (m_st[sup][i] == 2) begin
          e_mem.push_back((1 << 24) | (a << 16) | m_data[sup][i]);
          ref_mem[a] = m_data[sup][i];
        end
      end else begin
        e_mem.push_back(a << 16);
        m_data[p][i] = ref_mem[a];
        from_mem = 1;
        e_lat++;
      end
      e_bus = op;
    end
    for (int q = 0; q < NP; q++)
      if (q != p && m_st[q][i] != 0 && m_tag[q][i] == t) begin
        if (op == 0) m_st[q][i] = 0;
        else if (!e_hit) m_st[q][i] = 1;
      end
    m_tag[p][i] = t;
    if (op == 0) begin
      m_st[p][i] = 2;
      m_data[p][i] = wd;
    end else if (!e_hit) m_st[p][i] = (MESI && from_mem) ? 3 : 1;
    e_rd = m_data[p][i];
  endtask
  task automatic check_lines();
    for (int p = 0; p < NP; p++)
      for (int l = 0; l < NL; l++) begin
        dbg_proc = 2'(p);
        dbg_index = 2'(l);
        #1;
        chk($sformatf("state_p%0d_l%0d", p, l), dbg_state, m_st[p][l]);
        chk($sformatf("tag_p%0d_l%0d", p, l), dbg_tag, m_tag[p][l]);
        chk($sformatf("data_p%0d_l%0d", p, l), dbg_data, m_data[p][l]);
      end
  endtask
  task automatic txn(input int p, input int i, input int t, input int op, input int wd);
    int lat;
    model(p, i, t, op, wd);
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_proc = 2'(p);
    req_index = 2'(i);
    req_tag = 3'(t);
    req_op = op[0];
    req_wdata = 16'(wd);
    obs_mem.delete();
    obs_bus.delete();
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    chk("ready_busy", req_ready, 0);
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, e_lat);
    chk("resp_hit", resp_hit, e_hit);
    chk("resp_err", resp_err, e_err);
    chk("resp_rdata", resp_rdata, e_rd);
    chk("bus_count", obs_bus.size(), e_bus < 0 ? 0 : 1);
    if (e_bus >= 0 && obs_bus.size() > 0) chk("bus_msg", obs_bus[0], e_bus);
    chk("mem_count", obs_mem.size(), e_mem.size());
    for (int k = 0; k < obs_mem.size() && k < e_mem.size(); k++) chk("mem_op", obs_mem[k], e_mem[k]);
    check_lines();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("ready_in_reset", req_ready, 0);
    rst = 1'b0;
    model_clear();
    #1 chk("ready_after_reset", req_ready, 1);
  endtask
  initial begin
    for (int a = 0; a < 32; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = int'(mem[a]);
    end
    mem[21] = 16'h0030;
    ref_mem[21] = 32'h0030;
    do_reset();
    check_lines();
    txn(0, 1, 5, 1, 0);
    txn(1, 1, 5, 0, 16'h00AA);
    txn(2, 1, 5, 1, 0);
    txn(1, 1, 6, 0, 16'h0011);
    txn(1, 1, 7, 1, 0);
    txn(0, 2, 3, 1, 0);
    txn(0, 2, 3, 0, 16'h0055);
    txn(0, 2, 3, 1, 0);
    txn(3, 0, 1, 1, 0);
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_proc = 2'd0;
    req_index = 2'd3;
    req_tag = 3'd4;
    req_op = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    obs_bus.delete();
    obs_mem.delete();
    @(posedge clk);
    #1 chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_bus_valid", bus_valid, 0);
    model_clear();
    check_lines();
    rst = 1'b0;
    #1 chk("rst_release_ready", req_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("rst_no_bus", obs_bus.size(), 0);
    chk("rst_no_mem", obs_mem.size(), 0);
    for (int n = 0; n < 200; n++) begin
      int p, t;
      p = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, 2));
      t = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
      txn(p, int'($urandom_range(0, 3)), t, int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
